// File: rtl/clock_enable_controller.sv
// -----------------------------------------------------------------------------
// clock_enable_controller
//
// Per-domain clock-enable sequencer for the FIR, FFT and DMA engines. Each
// domain runs its own small FSM (OFF -> WAKE -> ON -> DRAIN -> OFF) on the
// ungated clk_in domain and drives the matching enable_* input of
// clock_manager. A grant is issued once the gated clock has had WAKE_CYCLES
// cycles to settle. The clock is held on through a DRAIN period until the
// engine has been idle for IDLE_TIMEOUT consecutive cycles.
//
// Optional feature: define CLKEN_FORCE_EN to add a force_on input that holds
// every enable (and any_on) high without disturbing the FSMs or the grants.
// -----------------------------------------------------------------------------
module clock_enable_controller #(
  parameter int WAKE_CYCLES  = 2,
  parameter int IDLE_TIMEOUT = 16,
  parameter int CNT_W        = 8
) (
  input  logic clk_in,
  input  logic reset,
`ifdef CLKEN_FORCE_EN
  input  logic force_on,
`endif
  input  logic req_fir,
  input  logic req_fft,
  input  logic req_dma,
  input  logic idle_fir,
  input  logic idle_fft,
  input  logic idle_dma,
  output logic enable_fir,
  output logic enable_fft,
  output logic enable_dma,
  output logic grant_fir,
  output logic grant_fft,
  output logic grant_dma,
  output logic any_on
);

  // Three bits of encoding leave spare codes so a corrupted state register
  // has somewhere to go: every unused code decodes back to OFF.
  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_WAKE  = 3'd1,
    ST_ON    = 3'd2,
    ST_DRAIN = 3'd3
  } state_e;

  localparam int N_DOM = 3;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_TIMEOUT);

  // Domain index 0 = FIR, 1 = FFT, 2 = DMA throughout.
  logic [N_DOM-1:0] req_s;
  logic [N_DOM-1:0] idle_s;
  logic             force_s;

  state_e           state_r     [N_DOM];
  logic [CNT_W-1:0] cnt_r       [N_DOM];
  state_e           state_nxt_s [N_DOM];
  logic [CNT_W-1:0] cnt_nxt_s   [N_DOM];

  logic [N_DOM-1:0] en_nxt_s;
  logic [N_DOM-1:0] grant_nxt_s;
  logic [N_DOM-1:0] en_out_s;

  logic [N_DOM-1:0] enable_r;
  logic [N_DOM-1:0] grant_r;
  logic             any_on_r;

  assign req_s  = {req_dma,  req_fft,  req_fir};
  assign idle_s = {idle_dma, idle_fft, idle_fir};

`ifdef CLKEN_FORCE_EN
  assign force_s = force_on;
`else
  assign force_s = 1'b0;
`endif

  // Next-state and next-counter logic for each independent domain FSM.
  always_comb begin
    for (int d = 0; d < N_DOM; d++) begin
      state_nxt_s[d] = ST_OFF;
      cnt_nxt_s[d]   = CNT_ZERO;
      case (state_r[d])
        ST_OFF: begin
          if (req_s[d]) begin
            state_nxt_s[d] = ST_WAKE;
            cnt_nxt_s[d]   = WAKE_LOAD;
          end else begin
            state_nxt_s[d] = ST_OFF;
            cnt_nxt_s[d]   = CNT_ZERO;
          end
        end
        ST_WAKE: begin
          // The wake always completes; req only decides where it lands.
          // A count of zero can only come from corruption and is treated
          // as expiry so the domain never sticks in WAKE.
          if (cnt_r[d] <= CNT_ONE) begin
            if (req_s[d]) begin
              state_nxt_s[d] = ST_ON;
              cnt_nxt_s[d]   = CNT_ZERO;
            end else begin
              state_nxt_s[d] = ST_DRAIN;
              cnt_nxt_s[d]   = IDLE_LOAD;
            end
          end else begin
            state_nxt_s[d] = ST_WAKE;
            cnt_nxt_s[d]   = cnt_r[d] - CNT_ONE;
          end
        end
        ST_ON: begin
          if (!req_s[d]) begin
            state_nxt_s[d] = ST_DRAIN;
            cnt_nxt_s[d]   = IDLE_LOAD;
          end else begin
            state_nxt_s[d] = ST_ON;
            cnt_nxt_s[d]   = CNT_ZERO;
          end
        end
        ST_DRAIN: begin
          // A new request wins over timeout expiry: the clock is still
          // running, so the grant can return without another wake.
          if (req_s[d]) begin
            state_nxt_s[d] = ST_ON;
            cnt_nxt_s[d]   = CNT_ZERO;
          end else if (!idle_s[d]) begin
            state_nxt_s[d] = ST_DRAIN;
            cnt_nxt_s[d]   = IDLE_LOAD;
          end else if (cnt_r[d] <= CNT_ONE) begin
            state_nxt_s[d] = ST_OFF;
            cnt_nxt_s[d]   = CNT_ZERO;
          end else begin
            state_nxt_s[d] = ST_DRAIN;
            cnt_nxt_s[d]   = cnt_r[d] - CNT_ONE;
          end
        end
        default: begin
          state_nxt_s[d] = ST_OFF;
          cnt_nxt_s[d]   = CNT_ZERO;
        end
      endcase
    end
  end

  // Decode the next state into next enable/grant so the outputs can be
  // registered on the same edge as the state itself.
  always_comb begin
    en_nxt_s    = {N_DOM{1'b0}};
    grant_nxt_s = {N_DOM{1'b0}};
    for (int d = 0; d < N_DOM; d++) begin
      case (state_nxt_s[d])
        ST_OFF: begin
          en_nxt_s[d]    = 1'b0;
          grant_nxt_s[d] = 1'b0;
        end
        ST_WAKE: begin
          en_nxt_s[d]    = 1'b1;
          grant_nxt_s[d] = 1'b0;
        end
        ST_ON: begin
          en_nxt_s[d]    = 1'b1;
          grant_nxt_s[d] = 1'b1;
        end
        ST_DRAIN: begin
          en_nxt_s[d]    = 1'b1;
          grant_nxt_s[d] = 1'b0;
        end
        default: begin
          en_nxt_s[d]    = 1'b0;
          grant_nxt_s[d] = 1'b0;
        end
      endcase
    end
  end

  // force_on only overrides the enables; the FSMs and grants are untouched.
  always_comb begin
    en_out_s = en_nxt_s | {N_DOM{force_s}};
  end

  // State, counter and output registers; reset overrides everything.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int d = 0; d < N_DOM; d++) begin
        state_r[d] <= ST_OFF;
        cnt_r[d]   <= CNT_ZERO;
      end
      enable_r <= {N_DOM{1'b0}};
      grant_r  <= {N_DOM{1'b0}};
      any_on_r <= 1'b0;
    end else begin
      for (int d = 0; d < N_DOM; d++) begin
        state_r[d] <= state_nxt_s[d];
        cnt_r[d]   <= cnt_nxt_s[d];
      end
      enable_r <= en_out_s;
      grant_r  <= grant_nxt_s;
      any_on_r <= |en_out_s;
    end
  end

  assign enable_fir = enable_r[0];
  assign enable_fft = enable_r[1];
  assign enable_dma = enable_r[2];
  assign grant_fir  = grant_r[0];
  assign grant_fft  = grant_r[1];
  assign grant_dma  = grant_r[2];
  assign any_on     = any_on_r;

endmodule
